// File: rtl/ps2_arrow_decoder.sv
// PS/2 keyboard receiver in the vga_clk domain: synchronises and filters the PS/2 pins,
// receives 11-bit frames, and turns E0/F0-prefixed arrow scan codes into held key levels.
module ps2_arrow_decoder #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int TO_W           = 13
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err,
    output logic       key_up,
    output logic       key_down,
    output logic       key_left,
    output logic       key_right
);

    localparam int FW = $clog2(FILTER_LEN);
    localparam logic [FW-1:0]   FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic          clk_meta;
    logic          clk_sync;
    logic          data_meta;
    logic          data_sync;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          parity_ok;
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_next;

    logic          ext;
    logic          brk;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data;
            data_sync <= data_meta;
        end
    end

    // Any sample agreeing with the filtered level restarts the run, so short glitches never land.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_sync == clk_filt) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_LAST) begin
            clk_filt <= clk_sync;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign fall    = clk_filt & ~clk_sync & (filt_cnt == FILT_LAST);
    assign to_next = to_cnt + 1'b1;

    // Expiry is judged on the incremented count so the error lands TIMEOUT_CYCLES after the fall cycle.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity_ok  <= 1'b0;
            to_cnt     <= '0;
            scan_code  <= '0;
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (state == IDLE || fall) begin
                to_cnt <= '0;
            end else if (to_next == TO_LAST) begin
                to_cnt    <= '0;
                state     <= IDLE;
                frame_err <= 1'b1;
            end else begin
                to_cnt <= to_next;
            end

            if (fall) begin
                case (state)
                    IDLE: begin
                        if (!data_sync) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg   <= {data_sync, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_ok <= ^{shreg, data_sync};
                        state     <= STOP;
                    end
                    STOP: begin
                        if (data_sync && parity_ok) begin
                            scan_code  <= shreg;
                            scan_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Only E0-prefixed arrow codes touch the key levels; keypad codes without E0 are ignored.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            ext       <= 1'b0;
            brk       <= 1'b0;
            key_up    <= 1'b0;
            key_down  <= 1'b0;
            key_left  <= 1'b0;
            key_right <= 1'b0;
        end else if (frame_err) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (scan_valid) begin
            if (scan_code == 8'hE0) begin
                ext <= 1'b1;
            end else if (scan_code == 8'hF0) begin
                brk <= 1'b1;
            end else begin
                if (ext) begin
                    case (scan_code)
                        8'h75:   key_up    <= ~brk;
                        8'h72:   key_down  <= ~brk;
                        8'h6B:   key_left  <= ~brk;
                        8'h74:   key_right <= ~brk;
                        default: ;
                    endcase
                end
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// Directed bench for ps2_arrow_decoder: a vector table of single frames plus hand sequences
// for key-release timing, mid-frame timeout, clock glitches and mid-frame reset.
module tb_ps2_arrow_decoder;

    localparam int HALF = 60;

    logic       vga_clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;
    logic       key_up;
    logic       key_down;
    logic       key_left;
    logic       key_right;
    logic [3:0] keys;

    int cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int last_valid_cyc = 0;
    int last_err_cyc = 0;
    int last_fall_cyc = 0;
    logic [3:0] keys_at_valid = '0;
    logic [3:0] keys_after_valid = '0;
    logic valid_d = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] code_in;
        bit         bad_par;
        int         exp_valid;
        int         exp_err;
        logic [7:0] exp_code;
        logic [3:0] exp_keys;
    } vec_t;

    vec_t vecs[19];

    ps2_arrow_decoder dut (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .frame_err  (frame_err),
        .key_up     (key_up),
        .key_down   (key_down),
        .key_left   (key_left),
        .key_right  (key_right)
    );

    assign keys = {key_up, key_down, key_left, key_right};

    always #20 vga_clk = ~vga_clk;

    always @(posedge vga_clk) cyc <= cyc + 1;

    always @(negedge vga_clk) begin
        if (scan_valid) begin
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc;
            keys_at_valid  <= keys;
        end
        if (frame_err) begin
            err_cnt      <= err_cnt + 1;
            last_err_cyc <= cyc;
        end
        if (valid_d) begin
            keys_after_valid <= keys;
        end
        valid_d <= scan_valid;
    end

    initial begin
        #(40 * 200000);
        $display("[TB] FAIL watchdog: simulation still running at cycle %0d, limit 200000", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge vga_clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Sends the first nbits of a frame (start, 8 data LSB-first, parity, stop); data moves mid-high.
    task automatic applyStimulus(input logic [7:0] code, input bit bad_par, input int nbits, input bit glitch);
        logic [10:0] bits;
        logic        par;
        par  = bad_par ? ^code : ~^code;
        bits = {1'b1, par, code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            if (glitch) begin
                waitCycles(10);
                ps2_clk = 1'b0;
                waitCycles(2);
                ps2_clk = 1'b1;
                waitCycles(18);
            end else begin
                waitCycles(HALF / 2);
            end
            ps2_data = bits[i];
            waitCycles(HALF / 2);
            ps2_clk       = 1'b0;
            last_fall_cyc = cyc;
            waitCycles(HALF);
            ps2_clk = 1'b1;
        end
        waitCycles(HALF);
        ps2_data = 1'b1;
        waitCycles(40);
    endtask

    initial begin
        int v0;
        int e0;
        int fall_ref;

        vecs[0]  = '{8'hE0, 1'b0, 1, 0, 8'hE0, 4'b0000};
        vecs[1]  = '{8'h75, 1'b0, 1, 0, 8'h75, 4'b1000};
        vecs[2]  = '{8'hE0, 1'b0, 1, 0, 8'hE0, 4'b1000};
        vecs[3]  = '{8'hF0, 1'b0, 1, 0, 8'hF0, 4'b1000};
        vecs[4]  = '{8'h75, 1'b0, 1, 0, 8'h75, 4'b0000};
        vecs[5]  = '{8'h75, 1'b0, 1, 0, 8'h75, 4'b0000};
        vecs[6]  = '{8'h6B, 1'b1, 0, 1, 8'h75, 4'b0000};
        vecs[7]  = '{8'hE0, 1'b0, 1, 0, 8'hE0, 4'b0000};
        vecs[8]  = '{8'h6B, 1'b0, 1, 0, 8'h6B, 4'b0010};
        vecs[9]  = '{8'hE0, 1'b0, 1, 0, 8'hE0, 4'b0010};
        vecs[10] = '{8'h6B, 1'b0, 1, 0, 8'h6B, 4'b0010};
        vecs[11] = '{8'hE0, 1'b0, 1, 0, 8'hE0, 4'b0010};
        vecs[12] = '{8'hF0, 1'b0, 1, 0, 8'hF0, 4'b0010};
        vecs[13] = '{8'h74, 1'b0, 1, 0, 8'h74, 4'b0010};
        vecs[14] = '{8'hE0, 1'b0, 1, 0, 8'hE0, 4'b0010};
        vecs[15] = '{8'h72, 1'b1, 0, 1, 8'hE0, 4'b0010};
        vecs[16] = '{8'h72, 1'b0, 1, 0, 8'h72, 4'b0010};
        vecs[17] = '{8'hF0, 1'b0, 1, 0, 8'hF0, 4'b0010};
        vecs[18] = '{8'h72, 1'b0, 1, 0, 8'h72, 4'b0010};

        $display("[TB] reset state");
        waitCycles(5);
        checkOutput("reset scan_code", {24'd0, scan_code}, 32'h0);
        checkOutput("reset strobes", {30'd0, scan_valid, frame_err}, 32'h0);
        checkOutput("reset keys", {28'd0, keys}, 32'h0);
        reset = 1'b0;
        waitCycles(20);

        $display("[TB] vector table");
        for (int i = 0; i < 19; i++) begin
            v0 = valid_cnt;
            e0 = err_cnt;
            applyStimulus(vecs[i].code_in, vecs[i].bad_par, 11, 1'b0);
            checkOutput($sformatf("vec%0d valid count", i), valid_cnt - v0, vecs[i].exp_valid);
            checkOutput($sformatf("vec%0d error count", i), err_cnt - e0, vecs[i].exp_err);
            checkOutput($sformatf("vec%0d scan_code", i), {24'd0, scan_code}, {24'd0, vecs[i].exp_code});
            checkOutput($sformatf("vec%0d keys", i), {28'd0, keys}, {28'd0, vecs[i].exp_keys});
            if (vecs[i].exp_valid == 1) begin
                checkOutput($sformatf("vec%0d valid latency", i), last_valid_cyc - last_fall_cyc, 32'd6);
            end
        end

        $display("[TB] release timing");
        applyStimulus(8'hE0, 1'b0, 11, 1'b0);
        applyStimulus(8'h75, 1'b0, 11, 1'b0);
        checkOutput("press up keys", {28'd0, keys}, 32'b1010);
        applyStimulus(8'hE0, 1'b0, 11, 1'b0);
        applyStimulus(8'hF0, 1'b0, 11, 1'b0);
        applyStimulus(8'h75, 1'b0, 11, 1'b0);
        checkOutput("up during valid", {31'd0, keys_at_valid[3]}, 32'd1);
        checkOutput("up after valid", {31'd0, keys_after_valid[3]}, 32'd0);
        checkOutput("release keys", {28'd0, keys}, 32'b0010);

        $display("[TB] timeout");
        v0 = valid_cnt;
        e0 = err_cnt;
        applyStimulus(8'h5A, 1'b0, 4, 1'b0);
        fall_ref = last_fall_cyc;
        waitCycles(fall_ref + 5010 - cyc);
        checkOutput("timeout error count", err_cnt - e0, 32'd1);
        checkOutput("timeout error cycle", last_err_cyc - fall_ref, 32'd5005);
        checkOutput("timeout valid count", valid_cnt - v0, 32'd0);
        applyStimulus(8'hE0, 1'b0, 11, 1'b0);
        applyStimulus(8'h74, 1'b0, 11, 1'b0);
        checkOutput("after timeout scan_code", {24'd0, scan_code}, 32'h74);
        checkOutput("after timeout keys", {28'd0, keys}, 32'b0011);

        $display("[TB] glitches");
        v0 = valid_cnt;
        e0 = err_cnt;
        applyStimulus(8'hE0, 1'b0, 11, 1'b1);
        applyStimulus(8'h72, 1'b0, 11, 1'b1);
        checkOutput("glitch valid count", valid_cnt - v0, 32'd2);
        checkOutput("glitch error count", err_cnt - e0, 32'd0);
        checkOutput("glitch scan_code", {24'd0, scan_code}, 32'h72);
        checkOutput("glitch keys", {28'd0, keys}, 32'b0111);

        $display("[TB] mid-frame reset");
        v0 = valid_cnt;
        e0 = err_cnt;
        applyStimulus(8'h6B, 1'b0, 5, 1'b0);
        reset = 1'b1;
        waitCycles(1);
        checkOutput("mid reset scan_code", {24'd0, scan_code}, 32'h0);
        checkOutput("mid reset strobes", {30'd0, scan_valid, frame_err}, 32'h0);
        checkOutput("mid reset keys", {28'd0, keys}, 32'h0);
        waitCycles(3);
        reset = 1'b0;
        waitCycles(5100);
        checkOutput("post reset error count", err_cnt - e0, 32'd0);
        checkOutput("post reset valid count", valid_cnt - v0, 32'd0);
        applyStimulus(8'hE0, 1'b0, 11, 1'b0);
        applyStimulus(8'h6B, 1'b0, 11, 1'b0);
        checkOutput("post reset frames", valid_cnt - v0, 32'd2);
        checkOutput("post reset scan_code", {24'd0, scan_code}, 32'h6B);
        checkOutput("post reset keys", {28'd0, keys}, 32'b0010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
